// File: rtl/dp_result_collector.sv
// Result collector for the matmul dot-product stream: buffers results in a small FIFO,
// tags them with (row, col) and hands out issue credits so the un-stallable pipeline never overruns it.
module dp_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 32,
    parameter int N          = 32,
    parameter int Q          = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int RES_W     = 2*DATA_WIDTH + $clog2(M),
    localparam int RW        = $clog2(N),
    localparam int CW        = $clog2(Q)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             in_valid,
    input  logic [RES_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             out_last,
    output logic             frame_done,
    output logic             overflow,
    output logic             credit_err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    logic [RES_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [CNTW-1:0]  credits_q, credits_d;
    logic [RES_W-1:0] out_data_q, head_d;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             frame_done_q, overflow_q, credit_err_q;
    logic             full, pop, push, issue_take;

    assign full       = (count_q == CNTW'(FIFO_DEPTH));
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid & out_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push       = in_valid & (~full | pop);
    assign issue_take = issue & (credits_q != '0);

    assign issue_ok   = (credits_q != '0);
    assign out_data   = out_data_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = (row_q == RW'(N-1)) && (col_q == CW'(Q-1));
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign credit_err = credit_err_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNTW'(1);
        else if (pop && !push)
            count_d = count_q - CNTW'(1);
    end

    // Head register is loaded with the next head, so a fresh write shows up one cycle later.
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? in_data : mem_q[rd_ptr_d];
    end

    always_comb begin
        credits_d = credits_q;
        if (issue_take && !pop)
            credits_d = credits_q - CNTW'(1);
        else if (pop && !issue_take && credits_q != CNTW'(FIFO_DEPTH))
            credits_d = credits_q + CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            credits_q    <= CNTW'(FIFO_DEPTH);
            out_data_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            if (count_d != '0)
                out_data_q <= head_d;
            frame_done_q <= pop & out_last;
            if (in_valid && full && !pop)
                overflow_q <= 1'b1;
            if (issue && credits_q == '0)
                credit_err_q <= 1'b1;
            if (pop) begin
                if (out_last) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (col_q == CW'(Q-1)) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dp_result_collector.sv
// Directed bench for dp_result_collector with a 2x3 frame and an 8-deep FIFO.
module tb_dp_result_collector;

    localparam int DW    = 16;
    localparam int M     = 32;
    localparam int N     = 2;
    localparam int Q     = 3;
    localparam int D     = 8;
    localparam int RES_W = 2*DW + $clog2(M);
    localparam int RW    = $clog2(N);
    localparam int CW    = $clog2(Q);

    logic             clk = 1'b0;
    logic             reset, issue, issue_ok, in_valid, out_valid, out_ready;
    logic [RES_W-1:0] in_data, out_data;
    logic [RW-1:0]    out_row;
    logic [CW-1:0]    out_col;
    logic             out_last, frame_done, overflow, credit_err;

    int vectors     = 0;
    int miscompares = 0;

    dp_result_collector #(
        .DATA_WIDTH(DW), .M(M), .N(N), .Q(Q), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset), .issue(issue), .issue_ok(issue_ok),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .frame_done(frame_done), .overflow(overflow), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; issue = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"},  RES_W'(out_valid),  '0);
        chk({tag, "_data"},   out_data,           '0);
        chk({tag, "_row"},    RES_W'(out_row),    '0);
        chk({tag, "_col"},    RES_W'(out_col),    '0);
        chk({tag, "_last"},   RES_W'(out_last),   '0);
        chk({tag, "_fdone"},  RES_W'(frame_done), '0);
        chk({tag, "_ovf"},    RES_W'(overflow),   '0);
        chk({tag, "_cerr"},   RES_W'(credit_err), '0);
        chk({tag, "_issok"},  RES_W'(issue_ok),   RES_W'(1));
    endtask

    logic signed [RES_W-1:0] neg;
    logic [RES_W-1:0]        prev_data;
    logic                    prev_stall;
    int                      nexp;
    logic [RES_W-1:0]        drain_exp [8];

    initial begin
        reset = 1'b1; issue = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_reset_state("rst");

        // Credit accounting: 8 credits, then a 9th issue is an error.
        out_ready = 1'b0; issue = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("cred7_issok", RES_W'(issue_ok), RES_W'(1));
            if (i == 8) chk("cred8_issok", RES_W'(issue_ok), '0);
        end
        tick();
        chk("cred9_err",   RES_W'(credit_err), RES_W'(1));
        chk("cred9_issok", RES_W'(issue_ok),   '0);
        issue = 1'b0;
        do_reset();

        // Single negative result, no bypass, credit returned on handshake.
        issue = 1'b1; tick(); issue = 1'b0;
        neg = -12345;
        out_ready = 1'b1; in_valid = 1'b1; in_data = neg;
        chk("one_nobypass", RES_W'(out_valid), '0);
        tick();
        in_valid = 1'b0;
        chk("one_valid", RES_W'(out_valid), RES_W'(1));
        chk("one_data",  out_data,          neg);
        chk("one_row",   RES_W'(out_row),   '0);
        chk("one_col",   RES_W'(out_col),   '0);
        tick();
        chk("one_empty", RES_W'(out_valid), '0);
        chk("one_hold",  out_data,          neg);
        chk("one_col1",  RES_W'(out_col),   RES_W'(1));
        out_ready = 1'b0; issue = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("one_cred7", RES_W'(issue_ok), RES_W'(1));
            if (i == 8) chk("one_cred8", RES_W'(issue_ok), '0);
        end
        issue = 1'b0;
        do_reset();

        // Full 2x3 frame with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = RES_W'(i);
            tick();
            chk($sformatf("frm%0d_valid", i), RES_W'(out_valid),  RES_W'(1));
            chk($sformatf("frm%0d_data", i),  out_data,           RES_W'(i));
            chk($sformatf("frm%0d_row", i),   RES_W'(out_row),    RES_W'((i-1)/3));
            chk($sformatf("frm%0d_col", i),   RES_W'(out_col),    RES_W'((i-1)%3));
            chk($sformatf("frm%0d_last", i),  RES_W'(out_last),   RES_W'(i == 6));
            chk($sformatf("frm%0d_fdone", i), RES_W'(frame_done), '0);
        end
        in_valid = 1'b0;
        tick();
        chk("frm_fdone",   RES_W'(frame_done), RES_W'(1));
        chk("frm_empty",   RES_W'(out_valid),  '0);
        chk("frm_row0",    RES_W'(out_row),    '0);
        chk("frm_col0",    RES_W'(out_col),    '0);
        tick();
        chk("frm_fdone_off", RES_W'(frame_done), '0);

        // Backpressure: out_ready toggles while 8 results stream in.
        do_reset();
        nexp = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 24; c++) begin
            in_valid  = (c < 8);
            in_data   = RES_W'(100 + c);
            out_ready = (c % 2 == 1);
            if (prev_stall) chk($sformatf("bp%0d_stable", c), out_data, prev_data);
            if (out_valid && out_ready) begin
                chk($sformatf("bp%0d_data", c), out_data, RES_W'(100 + nexp));
                nexp++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_count", RES_W'(nexp),     RES_W'(8));
        chk("bp_ovf",   RES_W'(overflow), '0);
        chk("bp_empty", RES_W'(out_valid), '0);

        // Full FIFO: push+pop is accepted, push alone overflows and drops.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = RES_W'(200 + i);
            tick();
        end
        chk("full_ovf0", RES_W'(overflow), '0);
        chk("full_head", out_data,         RES_W'(200));
        in_data = RES_W'(999); out_ready = 1'b1;
        tick();
        chk("pp_ovf",  RES_W'(overflow), '0);
        chk("pp_head", out_data,         RES_W'(201));
        in_data = RES_W'(777); out_ready = 1'b0;
        tick();
        chk("ovf_set",  RES_W'(overflow), RES_W'(1));
        chk("ovf_head", out_data,         RES_W'(201));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) drain_exp[k] = RES_W'(201 + k);
        drain_exp[7] = RES_W'(999);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_valid", k), RES_W'(out_valid), RES_W'(1));
            chk($sformatf("drain%0d_data", k),  out_data,          drain_exp[k]);
            tick();
        end
        chk("drain_empty", RES_W'(out_valid), '0);
        chk("ovf_sticky",  RES_W'(overflow),  RES_W'(1));

        // Reset mid-frame with buffered data and a credit error pending.
        do_reset();
        issue = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        issue = 1'b0;
        chk("mid_cerr", RES_W'(credit_err), RES_W'(1));
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = RES_W'(10 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_valid", RES_W'(out_valid), RES_W'(1));
        chk("mid_data",  out_data,          RES_W'(14));
        chk("mid_row",   RES_W'(out_row),   RES_W'(1));
        chk("mid_col",   RES_W'(out_col),   '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("midrst");
        in_valid = 1'b1; in_data = RES_W'(42);
        tick();
        in_valid = 1'b0;
        chk("post_valid", RES_W'(out_valid), RES_W'(1));
        chk("post_data",  out_data,          RES_W'(42));
        chk("post_row",   RES_W'(out_row),   '0);
        chk("post_col",   RES_W'(out_col),   '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dp_result_collector.md
Name: dp_result_collector

Overview:
- Receiving end of the pipelined dot-product result stream in the matmul datapath.
- Accepts one result per `in_valid` pulse, in row-major order, and buffers it in a small FIFO.
- Re-emits each result on a valid/ready output stream tagged with its (row, col) position.
- The dot-product pipeline has no backpressure, so the block grants issue credits; the issuer launches a dot product only while credit is available, which guarantees results are never dropped.

Parameters:
- DATA_WIDTH, 16, operand width of the dot-product engine.
- M, 32, dot-product vector length. Defines RES_W = 2*DATA_WIDTH + $clog2(M).
- N, 32, rows in the result matrix.
- Q, 32, columns in the result matrix.
- FIFO_DEPTH, 8, result buffer entries. Must be a power of 2 and at least 6 (pipeline latency 5 plus 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue  in  1  issuer launched one dot product this cycle (consumes one credit)
- issue_ok  out  1  at least one credit available
- in_valid  in  1  dot-product result valid (single-cycle pulse)
- in_data  in  RES_W  signed dot-product result
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_data  out  RES_W  signed result at FIFO head
- out_row  out  $clog2(N)  row index of out_data
- out_col  out  $clog2(Q)  column index of out_data
- out_last  out  1  out_data is element (N-1, Q-1)
- frame_done  out  1  one-cycle pulse after the last element handshakes
- overflow  out  1  sticky error: write attempted while FIFO full
- credit_err  out  1  sticky error: issue asserted while credits == 0

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, frame_done=0, overflow=0, credit_err=0, issue_ok=1.
  - Internal state: FIFO empty, credits=FIFO_DEPTH.
  - Reset mid-frame discards all buffered data and in-flight credit state. Results arriving after reset are treated as the start of a new frame.
- Credits:
  - Counter range 0..FIFO_DEPTH.
  - issue alone decrements; output handshake (out_valid & out_ready) alone increments; both in the same cycle leave it unchanged.
  - issue with credits==0 sets credit_err and is otherwise ignored (counter stays 0).
  - issue_ok = (credits != 0), combinational from the counter.
- FIFO write:
  - Write occurs when in_valid is high.
  - If full and no pop in the same cycle: data is dropped and overflow sets.
  - If full and a pop occurs in the same cycle: the write is accepted and occupancy is unchanged.
- FIFO read:
  - No combinational bypass. A write at cycle t is visible as out_valid at t+1 at the earliest.
  - out_valid = !empty.
  - out_data, out_row and out_col are stable while out_valid & !out_ready.
- Position counters:
  - Advance only on handshake. out_col increments; at Q-1 it wraps to 0 and out_row increments.
  - out_last = (out_row==N-1 && out_col==Q-1).
  - On the handshake of the last element, both counters return to 0 and frame_done pulses high exactly in the next cycle.
- Empty FIFO: out_valid=0; out_data holds its last value; counters hold.
- Arithmetic: data passes through unmodified. No sign extension or truncation; width is RES_W end to end.
- Sticky flags: overflow and credit_err clear only on reset.

Test Plan:
1. Credit accounting, FIFO_DEPTH=8, out_ready=0 → issue 8 times: issue_ok falls after the 8th. A 9th issue sets credit_err; credits stay 0.
2. Single result → in_valid with in_data=-12345 at cycle t, out_ready=1: out_valid=1 at t+1 with out_data=-12345, out_row=0, out_col=0. After the handshake, credits are restored.
3. Full frame, N=2 Q=3 → 6 results with values 1..6, out_ready=1: (row,col) sequence is (0,0)(0,1)(0,2)(1,0)(1,1)(1,2). out_last is high only on value 6; frame_done pulses one cycle after that handshake; counters return to (0,0).
4. Backpressure → out_ready toggled 1/0 each cycle while 8 results stream in: no loss, order preserved, out_data held stable during stall cycles. overflow stays 0.
5. Full with simultaneous push/pop → FIFO at 8 entries, in_valid=1 and out_ready=1 in the same cycle: write accepted, occupancy stays 8, overflow=0. The same stimulus with out_ready=0 sets overflow and drops the value.
6. Reset mid-frame → after 4 results of a 2x3 frame, assert reset for 1 cycle: all outputs are at reset values and issue_ok=1. The next result emerges tagged (0,0).
